// File: rtl/square_wave_period_meter.sv
// Period and high-time meter for a sampled square wave.
// A hysteresis comparator finds the edges, and sample counters measure the time between them.
module square_wave_period_meter #(
  parameter logic signed [15:0] THRESH_HIGH     = 16'sd4096,
  parameter logic signed [15:0] THRESH_LOW      = -16'sd4096,
  parameter int                 COUNT_WIDTH     = 20,
  parameter int                 TIMEOUT_SAMPLES = 48000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   audio_clk_en,
  input  logic signed [15:0]     in,
  output logic [COUNT_WIDTH-1:0] period,
  output logic [COUNT_WIDTH-1:0] high_time,
  output logic                   valid,
  output logic                   no_signal
);

  localparam logic [1:0] ST_UNKNOWN = 2'd0;
  localparam logic [1:0] ST_LOW     = 2'd1;
  localparam logic [1:0] ST_HIGH    = 2'd2;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LIM = COUNT_WIDTH'(TIMEOUT_SAMPLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = COUNT_WIDTH'(1);

  logic [1:0]             r_state;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [COUNT_WIDTH-1:0] r_high_latch;
  logic                   r_armed;
  logic [COUNT_WIDTH-1:0] r_period;
  logic [COUNT_WIDTH-1:0] r_high_time;
  logic                   r_valid;
  logic                   r_no_signal;

  logic                   w_at_high;
  logic                   w_at_low;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_timeout;
  logic [1:0]             w_state_nxt;
  logic [COUNT_WIDTH-1:0] w_cnt_inc;

  // Comparator decisions, next state and saturating count for the current sample
  always_comb begin
    w_at_high   = (in >= THRESH_HIGH);
    w_at_low    = (in <= THRESH_LOW);
    w_rise      = (r_state == ST_LOW) && w_at_high;
    w_fall      = (r_state == ST_HIGH) && w_at_low;
    w_timeout   = !w_rise && (r_cnt >= TIMEOUT_LIM);
    w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
    w_state_nxt = r_state;
    case (r_state)
      ST_UNKNOWN: begin
        if (w_at_high) begin
          w_state_nxt = ST_HIGH;
        end else if (w_at_low) begin
          w_state_nxt = ST_LOW;
        end else begin
          w_state_nxt = ST_UNKNOWN;
        end
      end
      ST_LOW: begin
        if (w_at_high) begin
          w_state_nxt = ST_HIGH;
        end else begin
          w_state_nxt = ST_LOW;
        end
      end
      ST_HIGH: begin
        if (w_at_low) begin
          w_state_nxt = ST_LOW;
        end else begin
          w_state_nxt = ST_HIGH;
        end
      end
      default: w_state_nxt = ST_UNKNOWN;
    endcase
  end

  // Measurement state; a rise on the same sample as the timeout takes priority
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_UNKNOWN;
      r_cnt        <= '0;
      r_high_latch <= '0;
      r_armed      <= 1'b0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_valid      <= 1'b0;
      r_no_signal  <= 1'b1;
    end else begin
      r_valid <= 1'b0;
      if (audio_clk_en) begin
        r_state <= w_state_nxt;
        r_cnt   <= w_rise ? CNT_ONE : w_cnt_inc;
        if (w_fall) begin
          r_high_latch <= r_cnt;
        end
        if (w_rise) begin
          if (r_armed) begin
            r_period    <= r_cnt;
            r_high_time <= r_high_latch;
            r_valid     <= 1'b1;
            r_no_signal <= 1'b0;
          end else begin
            r_armed <= 1'b1;
          end
        end else if (w_timeout) begin
          r_no_signal <= 1'b1;
          r_armed     <= 1'b0;
          r_period    <= '0;
          r_high_time <= '0;
        end
      end
    end
  end

  assign period    = r_period;
  assign high_time = r_high_time;
  assign valid     = r_valid;
  assign no_signal = r_no_signal;

endmodule

// File: tb/tb_square_wave_period_meter.sv
// Self-checking bench for square_wave_period_meter: directed waveforms plus random levels,
// checked every clock against an index-based reference model.
module tb_square_wave_period_meter;

  localparam int CW      = 20;
  localparam int TIMEOUT = 48000;
  localparam longint CMAX = (longint'(1) << CW) - 1;

  logic                 clk;
  logic                 reset;
  logic                 audio_clk_en;
  logic signed [15:0]   in;
  logic [CW-1:0]        period;
  logic [CW-1:0]        high_time;
  logic                 valid;
  logic                 no_signal;

  int vectors;
  int miscompares;

  // Reference model: edges located by sample index, measurements are index differences
  int            m_state;   // -1 unknown, 0 low, 1 high
  longint        m_j;       // enabled samples seen since reset
  longint        m_anchor;  // index of last rising-edge sample (0 after reset)
  bit            m_armed;
  longint        m_hl;
  logic [CW-1:0] e_period;
  logic [CW-1:0] e_high;
  logic          e_valid;
  logic          e_nos;

  square_wave_period_meter dut (
    .clk          (clk),
    .reset        (reset),
    .audio_clk_en (audio_clk_en),
    .in           (in),
    .period       (period),
    .high_time    (high_time),
    .valid        (valid),
    .no_signal    (no_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = -1;
    m_j      = 0;
    m_anchor = 0;
    m_armed  = 1'b0;
    m_hl     = 0;
    e_period = '0;
    e_high   = '0;
    e_valid  = 1'b0;
    e_nos    = 1'b1;
  endtask

  task automatic model_sample(input int v);
    longint cnt;
    bit rise, fall;
    cnt = m_j - m_anchor;
    if (cnt > CMAX) cnt = CMAX;
    rise = (m_state == 0) && (v >= 4096);
    fall = (m_state == 1) && (v <= -4096);
    e_valid = 1'b0;
    if (rise) begin
      if (m_armed) begin
        e_period = CW'(cnt);
        e_high   = CW'(m_hl);
        e_valid  = 1'b1;
        e_nos    = 1'b0;
      end
      m_armed  = 1'b1;
      m_anchor = m_j;
    end else if (cnt >= TIMEOUT - 1) begin
      e_nos    = 1'b1;
      m_armed  = 1'b0;
      e_period = '0;
      e_high   = '0;
    end
    if (fall) m_hl = cnt;
    if (v >= 4096) m_state = 1;
    else if (v <= -4096) m_state = 0;
    m_j++;
  endtask

  task automatic tick(input logic en, input int v, input logic rst);
    reset        = rst;
    audio_clk_en = en;
    in           = 16'(v);
    @(posedge clk);
    if (rst) model_reset();
    else if (en) model_sample(v);
    else e_valid = 1'b0;
    #1;
    chk("period", 32'(period), 32'(e_period));
    chk("high_time", 32'(high_time), 32'(e_high));
    chk("valid", 32'(valid), 32'(e_valid));
    chk("no_signal", 32'(no_signal), 32'(e_nos));
  endtask

  function automatic int hi_val();
    if ($urandom_range(0, 3) == 0) return 4096;
    return 4096 + int'($urandom_range(0, 28000));
  endfunction

  function automatic int lo_val();
    if ($urandom_range(0, 3) == 0) return -4096;
    return -4096 - int'($urandom_range(0, 28000));
  endfunction

  function automatic int mid_val();
    return int'($urandom_range(0, 8190)) - 4095;
  endfunction

  // One enabled sample followed by div-1 idle clocks carrying junk on the input
  task automatic sample(input int v, input int div);
    tick(1'b1, v, 1'b0);
    for (int k = 1; k < div; k++) tick(1'b0, int'($urandom_range(0, 65535)) - 32768, 1'b0);
  endtask

  task automatic wave(input int n_cyc, input int hi_len, input int lo_len, input int div, input bit glitch);
    for (int c = 0; c < n_cyc; c++) begin
      for (int s = 0; s < lo_len; s++) sample(lo_val(), div);
      for (int s = 0; s < hi_len; s++) sample((glitch && s == hi_len / 2) ? 0 : hi_val(), div);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    reset = 1'b1; audio_clk_en = 1'b0; in = '0;

    // Reset state
    tick(1'b0, 0, 1'b1);
    tick(1'b1, 16000, 1'b1);

    // Fixed 10/10 wave, enable every clock
    wave(6, 10, 10, 1, 1'b0);
    chk("lock_period", 32'(period), 32'd20);
    chk("lock_high", 32'(high_time), 32'd10);
    chk("lock_nos", 32'(no_signal), 32'd0);

    // Same wave with enable every 4th clock
    wave(4, 10, 10, 4, 1'b0);
    chk("div4_period", 32'(period), 32'd20);
    chk("div4_high", 32'(high_time), 32'd10);

    // Duty change to 5 high / 15 low
    wave(3, 5, 15, 1, 1'b0);
    chk("duty_period", 32'(period), 32'd20);
    chk("duty_high", 32'(high_time), 32'd5);

    // Mid-level glitch inside each high phase
    wave(4, 10, 10, 1, 1'b1);
    chk("glitch_period", 32'(period), 32'd20);
    chk("glitch_high", 32'(high_time), 32'd10);

    // Hold low past the timeout, then restart
    for (int s = 0; s < TIMEOUT + 10; s++) sample(lo_val(), 1);
    chk("to_nos", 32'(no_signal), 32'd1);
    chk("to_period", 32'(period), 32'd0);
    chk("to_high", 32'(high_time), 32'd0);
    wave(3, 10, 10, 1, 1'b0);
    chk("restart_period", 32'(period), 32'd20);

    // Reset in the middle of a high phase
    wave(1, 10, 10, 1, 1'b0);
    for (int s = 0; s < 10; s++) sample(lo_val(), 1);
    for (int s = 0; s < 4; s++) sample(hi_val(), 1);
    tick(1'b1, hi_val(), 1'b1);
    chk("rst_nos", 32'(no_signal), 32'd1);
    chk("rst_period", 32'(period), 32'd0);
    for (int s = 0; s < 6; s++) sample(hi_val(), 1);
    wave(3, 10, 10, 1, 1'b0);
    chk("post_rst_period", 32'(period), 32'd20);

    // Random phase lengths, levels, mid-level noise and enable spacing
    for (int p = 0; p < 80; p++) begin
      int len, div;
      bit hi;
      len = int'($urandom_range(1, 30));
      div = int'($urandom_range(1, 3));
      hi  = p[0];
      for (int s = 0; s < len; s++) begin
        if ($urandom_range(0, 9) < 3) sample(mid_val(), div);
        else sample(hi ? hi_val() : lo_val(), div);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
